// File: rtl/ysyx_24080014_alu_arb.sv
// Round-robin arbiter sharing one combinational ALU between EXU (port 0) and LSU (port 1).
// Operands are registered onto the ALU, the result is buffered, and it is returned to the owning port.
module ysyx_24080014_alu_arb #(
    parameter int XLEN  = 32,
    parameter int CTL_W = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CTL_W-1:0] req0_op,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CTL_W-1:0] req1_op,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CTL_W-1:0] alu_ctl,
    output logic [XLEN-1:0]  alu_rs1,
    output logic [XLEN-1:0]  alu_rs2,
    input  logic [XLEN-1:0]  alu_out
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_reg, state_next;
    logic               prio_reg;
    logic               owner_reg;
    logic [CTL_W-1:0]   alu_ctl_reg;
    logic [XLEN-1:0]    alu_rs1_reg, alu_rs2_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [XLEN-1:0]    buf_data_reg;
    logic [TAG_W-1:0]   buf_tag_reg;

    logic [1:0]         req_valid, req_ready, rsp_ready_v, rsp_valid_v;
    logic               rsp_fire, can_accept, accept, grant;
    logic [CTL_W-1:0]   sel_op;
    logic [XLEN-1:0]    sel_a, sel_b;
    logic [TAG_W-1:0]   sel_tag;

    assign req_valid   = {req1_valid, req0_valid};
    assign rsp_ready_v = {rsp1_ready, rsp0_ready};

    // Acceptance is gated by rst_n so nothing is granted while reset is held.
    assign rsp_fire   = (state_reg == RESP) && rsp_ready_v[owner_reg];
    assign can_accept = rst_n && ((state_reg == IDLE) || rsp_fire);
    assign accept     = can_accept && (|req_valid);
    assign grant      = (&req_valid) ? prio_reg : req_valid[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready[gi]   = accept && (grant == 1'(gi));
            assign rsp_valid_v[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign rsp0_valid = rsp_valid_v[0];
    assign rsp1_valid = rsp_valid_v[1];

    assign sel_op  = grant ? req1_op  : req0_op;
    assign sel_a   = grant ? req1_a   : req0_a;
    assign sel_b   = grant ? req1_b   : req0_b;
    assign sel_tag = grant ? req1_tag : req0_tag;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_fire) state_next = accept ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            prio_reg     <= 1'b0;
            owner_reg    <= 1'b0;
            alu_ctl_reg  <= '1;
            alu_rs1_reg  <= '0;
            alu_rs2_reg  <= '0;
            tag_reg      <= '0;
            buf_data_reg <= '0;
            buf_tag_reg  <= '0;
        end else begin
            state_reg <= state_next;
            // Priority passes to the port that lost (or did not request) this grant.
            if (accept) begin
                prio_reg    <= ~grant;
                owner_reg   <= grant;
                alu_ctl_reg <= sel_op;
                alu_rs1_reg <= sel_a;
                alu_rs2_reg <= sel_b;
                tag_reg     <= sel_tag;
            end
            if (state_reg == EXEC) begin
                buf_data_reg <= alu_out;
                buf_tag_reg  <= tag_reg;
            end
        end
    end

    assign alu_ctl  = alu_ctl_reg;
    assign alu_rs1  = alu_rs1_reg;
    assign alu_rs2  = alu_rs2_reg;
    assign rsp_data = buf_data_reg;
    assign rsp_tag  = buf_tag_reg;

endmodule
